// File: rtl/dac_playback_sequencer.sv
// Streams {I,Q} sample pairs from sample memory to the DAC at a programmed rate, one-shot or loop.
// Optional DAC power-down request in IDLE is enabled by defining DAC_SEQ_PWRDN_EN.
module dac_playback_sequencer #(
    parameter int unsigned DAC_WIDTH = 10,
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned IDLE_CODE = 512
) (
    input  logic                   SPLB_Clk,
    input  logic                   SPLB_Rst,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic                   cfg_loop,
    input  logic [ADDR_W-1:0]      cfg_len,
    input  logic [15:0]            cfg_div,
    output logic                   mem_rd_en,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [2*DAC_WIDTH-1:0] mem_rd_data,
    output logic [DAC_WIDTH-1:0]   dac_i,
    output logic [DAC_WIDTH-1:0]   dac_q,
    output logic                   dac_strobe,
    output logic                   busy,
    output logic                   done,
    output logic                   S_PWRDN
);

    localparam logic [DAC_WIDTH-1:0] IdleCode = DAC_WIDTH'(IDLE_CODE);

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

    state_e                 state_q;
    logic                   mem_rd_en_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic                   data_vld_q;
    logic [2*DAC_WIDTH-1:0] prefetch_q;
    logic [DAC_WIDTH-1:0]   dac_i_q;
    logic [DAC_WIDTH-1:0]   dac_q_q;
    logic                   dac_strobe_q;
    logic                   done_q;
    logic [ADDR_W-1:0]      len_m1_q;
    logic [15:0]            div_q;
    logic [15:0]            cnt_q;
    logic [ADDR_W-1:0]      cur_q;
    logic                   end_q;

    always_ff @(posedge SPLB_Clk or posedge SPLB_Rst) begin
        if (SPLB_Rst) begin
            state_q      <= StIdle;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= '0;
            data_vld_q   <= 1'b0;
            prefetch_q   <= '0;
            dac_i_q      <= IdleCode;
            dac_q_q      <= IdleCode;
            dac_strobe_q <= 1'b0;
            done_q       <= 1'b0;
            len_m1_q     <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            cur_q        <= '0;
            end_q        <= 1'b0;
        end else begin
            dac_strobe_q <= 1'b0;
            done_q       <= 1'b0;
            // Read data is valid the cycle after the request.
            data_vld_q   <= mem_rd_en_q;
            if (state_q != StIdle && cfg_stop) begin
                state_q     <= StIdle;
                mem_rd_en_q <= 1'b0;
                data_vld_q  <= 1'b0;
                dac_i_q     <= IdleCode;
                dac_q_q     <= IdleCode;
                end_q       <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cfg_start && cfg_len != '0 && !cfg_stop) begin
                            len_m1_q    <= cfg_len - ADDR_W'(1);
                            div_q       <= (cfg_div < 16'd2) ? 16'd2 : cfg_div;
                            mem_rd_en_q <= 1'b1;
                            mem_addr_q  <= '0;
                            cur_q       <= '0;
                            end_q       <= 1'b0;
                            state_q     <= StPrime;
                        end
                    end
                    StPrime: begin
                        mem_rd_en_q <= 1'b0;
                        if (data_vld_q) begin
                            prefetch_q <= mem_rd_data;
                            cnt_q      <= '0;
                            state_q    <= StRun;
                        end
                    end
                    StRun: begin
                        mem_rd_en_q <= 1'b0;
                        if (data_vld_q) begin
                            prefetch_q <= mem_rd_data;
                        end
                        if (cnt_q == '0) begin
                            cnt_q <= div_q;
                            if (end_q) begin
                                // Tick after the last sample: finish without a strobe.
                                done_q  <= 1'b1;
                                dac_i_q <= IdleCode;
                                dac_q_q <= IdleCode;
                                end_q   <= 1'b0;
                                state_q <= StIdle;
                            end else begin
                                {dac_i_q, dac_q_q} <= prefetch_q;
                                dac_strobe_q       <= 1'b1;
                                if (cur_q == len_m1_q) begin
                                    if (cfg_loop) begin
                                        cur_q       <= '0;
                                        mem_rd_en_q <= 1'b1;
                                        mem_addr_q  <= '0;
                                    end else begin
                                        end_q <= 1'b1;
                                    end
                                end else begin
                                    cur_q       <= cur_q + ADDR_W'(1);
                                    mem_rd_en_q <= 1'b1;
                                    mem_addr_q  <= cur_q + ADDR_W'(1);
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign dac_i      = dac_i_q;
    assign dac_q      = dac_q_q;
    assign dac_strobe = dac_strobe_q;
    assign done       = done_q;
    assign busy       = (state_q != StIdle);

`ifdef DAC_SEQ_PWRDN_EN
    assign S_PWRDN = (state_q == StIdle);
`else
    assign S_PWRDN = 1'b0;
`endif

endmodule
